spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in io_clock cycles, legal range 2..255.
REQ-002 SHALL have parameter SS_IDLE_CYCLES, default 2: minimum cycles io_spi_ss stays high between transactions.
REQ-003 SHALL have ports:
 io_clock  in  1  system clock, single clock domain.
 io_reset  in  1  asynchronous, active-high reset.
 io_cmd_valid  in  1  command byte offered.
 io_cmd_ready  out  1  command byte accepted when valid&ready.
 io_cmd_data  in  8  byte to transmit, MSB first.
 io_cmd_last  in  1  deassert SS after this byte.
 io_rsp_valid  out  1  received byte available.
 io_rsp_ready  in  1  consumer takes byte when valid&ready.
 io_rsp_data  out  8  received byte.
 io_busy  out  1  high in any state except IDLE.
 io_spi_sclk  out  1  SPI clock, mode 0.
 io_spi_ss  out  1  slave select, active low.
 io_spi_mosi  out  1  serial data out.
 io_spi_miso  in  1  serial data in.

Function
REQ-004 SHALL implement states IDLE, SETUP, SHIFT, HOLD, DEASSERT.
REQ-005 SHALL assert io_cmd_ready only in IDLE and HOLD, and only when the response buffer is empty or being drained that cycle.
REQ-006 On accept in IDLE SHALL, next cycle, drive io_spi_ss low, io_spi_mosi = cmd_data[7], enter SETUP for CLK_DIV cycles.
REQ-007 SHIFT SHALL produce 8 SCLK periods; SCLK idles low, rises after each CLK_DIV-cycle low phase, falls after each CLK_DIV-cycle high phase.
REQ-008 SHALL sample io_spi_miso on the io_clock edge that raises SCLK; SHALL update io_spi_mosi to the next bit on the edge that lowers SCLK.
REQ-009 A byte SHALL occupy exactly 16*CLK_DIV cycles in SHIFT; after the 8th falling edge io_rsp_valid SHALL assert the next cycle with the shifted-in byte, MSB = first sampled bit.
REQ-010 io_rsp_valid/io_rsp_data SHALL hold stable until io_rsp_ready; one-entry buffer.
REQ-011 If the byte was not last SHALL enter HOLD with SS low and SCLK low; accept in HOLD SHALL restart SETUP-free SHIFT with MOSI = new bit 7 next cycle.
REQ-012 If last SHALL keep SS low CLK_DIV cycles, then drive SS high and enter DEASSERT for SS_IDLE_CYCLES cycles, then IDLE.
REQ-013 Full response buffer at frame end with a pending next byte SHALL stall in HOLD (cmd_ready low) until drained; no received byte SHALL be lost or overwritten.
REQ-014 rsp drain and cmd accept in the same cycle SHALL both succeed.
REQ-015 io_spi_mosi SHALL be 0 whenever io_spi_ss is high.

Reset
REQ-016 io_reset SHALL asynchronously force IDLE, io_spi_ss=1, io_spi_sclk=0, io_spi_mosi=0, io_cmd_ready=0, io_rsp_valid=0, io_rsp_data=0, io_busy=0.
REQ-017 io_cmd_ready SHALL rise one cycle after reset release; reset mid-frame SHALL abandon the frame with no response generated.

Configuration
REQ-018 With SPI_MASTER_LOOPBACK_EN defined SHALL add input io_loopback (1 bit); when high, the sampled input SHALL be internal MOSI instead of io_spi_miso, pins unchanged.
REQ-019 Without SPI_MASTER_LOOPBACK_EN, io_loopback SHALL not exist and io_spi_miso SHALL always be sampled.

Structure
REQ-020 State enum, SPI_BYTE_W=8 and default CLK_DIV SHALL live in package spi_master_pkg.
REQ-021 SCLK phase counter/edge strobes SHALL be sub-module spi_clk_gen (outputs rise/fall strobes); shifting and FSM stay in spi_master_ctrl.

Verification
REQ-022 Single byte 0xA5, last=1, MISO slave returns 0x3C, CLK_DIV=4 -> MOSI bits 1,0,1,0,0,1,0,1; rsp_data=0x3C; SS low 16*4+4+4 cycles.
REQ-023 Burst 0x01,0x02,0x03 (last on 3rd) -> SS low continuously, 24 SCLK rising edges, rsp 0xFF,0xFF,0xFF with MISO tied high.
REQ-024 rsp_ready held low during 2-byte burst -> cmd_ready low after byte 1, SCLK idle, first rsp held; release -> both bytes delivered in order.
REQ-025 Reset asserted mid-bit 4 -> same cycle SS=1, SCLK=0, rsp_valid=0; after release next 0x55 transfers cleanly.
REQ-026 SPI_MASTER_LOOPBACK_EN defined, io_loopback=1, send 0xC3 with MISO tied 0 -> rsp_data=0xC3.
REQ-027 Back-to-back last=1 commands -> SS high at least SS_IDLE_CYCLES=2 cycles between frames.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared state type, widths and defaults for the SPI master controller.
package spi_master_pkg;

    localparam int SPI_BYTE_W          = 8;
    localparam int SPI_BIT_CNT_W       = $clog2(SPI_BYTE_W);
    localparam int SPI_CLK_DIV_DEFAULT = 4;
    localparam int SPI_TMR_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DEASSERT
    } spi_state_t;

    // Down-counters expire on zero, so a duration of N cycles loads N-1.
    function automatic logic [SPI_TMR_W-1:0] tmr_load(input int cycles);
        return SPI_TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK phase timer: emits one-cycle rise/fall strobes every CLK_DIV cycles while enabled.
module spi_clk_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic io_clock,
    input  logic io_reset,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam logic [SPI_TMR_W-1:0] RELOAD = SPI_TMR_W'(CLK_DIV - 1);

    logic [SPI_TMR_W-1:0] phase_cnt;
    logic                 high_phase;
    logic                 tc;

    assign tc   = (phase_cnt == '0);
    assign rise = en && tc && !high_phase;
    assign fall = en && tc && high_phase;

    // Disabled means parked at the start of a low phase, ready for the next byte.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            phase_cnt  <= RELOAD;
            high_phase <= 1'b0;
        end else if (!en) begin
            phase_cnt  <= RELOAD;
            high_phase <= 1'b0;
        end else if (tc) begin
            phase_cnt  <= RELOAD;
            high_phase <= !high_phase;
        end else begin
            phase_cnt <= phase_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-stream SPI master (mode 0) with one-entry response buffer.
// Optional internal loopback of MOSI into the receive path: define SPI_MASTER_LOOPBACK_EN.
//
// state    | meaning
// IDLE     | SS high, waiting for a command byte
// SETUP    | SS low, MOSI holds bit 7, CLK_DIV cycles before the first SCLK low phase
// SHIFT    | 8 SCLK periods, sample on rise, shift MOSI on fall
// HOLD     | SS low, SCLK low; waits for the next byte, or times the SS tail after a last byte
// DEASSERT | SS high for SS_IDLE_CYCLES before returning to IDLE
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV        = SPI_CLK_DIV_DEFAULT,
    parameter int SS_IDLE_CYCLES = 2
) (
    input  logic                  io_clock,
    input  logic                  io_reset,
    input  logic                  io_cmd_valid,
    output logic                  io_cmd_ready,
    input  logic [SPI_BYTE_W-1:0] io_cmd_data,
    input  logic                  io_cmd_last,
    output logic                  io_rsp_valid,
    input  logic                  io_rsp_ready,
    output logic [SPI_BYTE_W-1:0] io_rsp_data,
    output logic                  io_busy,
    output logic                  io_spi_sclk,
    output logic                  io_spi_ss,
    output logic                  io_spi_mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  io_loopback,
`endif
    input  logic                  io_spi_miso
);

    spi_state_t              state;
    logic                    ready_en;
    logic [SPI_TMR_W-1:0]    tmr;
    logic [SPI_BIT_CNT_W-1:0] bits_left;
    logic                    last_q;
    logic [SPI_BYTE_W-2:0]   tx_rest;
    logic [SPI_BYTE_W-1:0]   rx_shift;
    logic                    sclk_q;
    logic                    ss_q;
    logic                    mosi_q;
    logic                    rsp_valid_q;
    logic [SPI_BYTE_W-1:0]   rsp_data_q;
    logic                    clk_rise;
    logic                    clk_fall;
    logic                    miso_sel;
    logic                    rsp_free;
    logic                    accept;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_sel = io_loopback ? mosi_q : io_spi_miso;
`else
    assign miso_sel = io_spi_miso;
`endif

    // A byte is only taken when its response has somewhere to land at frame end.
    assign rsp_free     = !rsp_valid_q || io_rsp_ready;
    assign io_cmd_ready = ready_en && rsp_free &&
                          ((state == ST_IDLE) || (state == ST_HOLD && !last_q));
    assign accept       = io_cmd_valid && io_cmd_ready;

    assign io_busy      = (state != ST_IDLE);
    assign io_spi_sclk  = sclk_q;
    assign io_spi_ss    = ss_q;
    assign io_spi_mosi  = mosi_q;
    assign io_rsp_valid = rsp_valid_q;
    assign io_rsp_data  = rsp_data_q;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .io_clock (io_clock),
        .io_reset (io_reset),
        .en       (state == ST_SHIFT),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            state       <= ST_IDLE;
            ready_en    <= 1'b0;
            tmr         <= '0;
            bits_left   <= '0;
            last_q      <= 1'b0;
            tx_rest     <= '0;
            rx_shift    <= '0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (rsp_valid_q && io_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ss_q    <= 1'b0;
                        mosi_q  <= io_cmd_data[SPI_BYTE_W-1];
                        tx_rest <= io_cmd_data[SPI_BYTE_W-2:0];
                        last_q  <= io_cmd_last;
                        tmr     <= tmr_load(CLK_DIV);
                        state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (tmr == '0) begin
                        bits_left <= SPI_BIT_CNT_W'(SPI_BYTE_W - 1);
                        state     <= ST_SHIFT;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (clk_rise) begin
                        sclk_q   <= 1'b1;
                        rx_shift <= {rx_shift[SPI_BYTE_W-2:0], miso_sel};
                    end
                    if (clk_fall) begin
                        sclk_q <= 1'b0;
                        if (bits_left == '0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rx_shift;
                            tmr         <= tmr_load(CLK_DIV);
                            state       <= ST_HOLD;
                        end else begin
                            bits_left <= bits_left - 1'b1;
                            mosi_q    <= tx_rest[SPI_BYTE_W-2];
                            tx_rest   <= {tx_rest[SPI_BYTE_W-3:0], 1'b0};
                        end
                    end
                end

                ST_HOLD: begin
                    if (last_q) begin
                        // SS tail after the final byte, then release the slave.
                        if (tmr == '0) begin
                            ss_q   <= 1'b1;
                            mosi_q <= 1'b0;
                            tmr    <= tmr_load(SS_IDLE_CYCLES);
                            state  <= ST_DEASSERT;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end else if (accept) begin
                        mosi_q    <= io_cmd_data[SPI_BYTE_W-1];
                        tx_rest   <= io_cmd_data[SPI_BYTE_W-2:0];
                        last_q    <= io_cmd_last;
                        bits_left <= SPI_BIT_CNT_W'(SPI_BYTE_W - 1);
                        state     <= ST_SHIFT;
                    end
                end

                ST_DEASSERT: begin
                    if (tmr == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: pin-level SPI slave model plus command/response scoreboards.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int SS_IDLE = 2;
    localparam int BUDGET  = 4000;

    logic       io_clock = 1'b0;
    logic       io_reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_last = 1'b0;
    logic       rsp_ready = 1'b0;
    logic       miso = 1'b0;
    logic       cmd_ready, rsp_valid, busy, sclk, ss, mosi;
    logic [7:0] rsp_data;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 io_clock = ~io_clock;

    spi_master_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .SS_IDLE_CYCLES (SS_IDLE)
    ) dut (
        .io_clock     (io_clock),
        .io_reset     (io_reset),
        .io_cmd_valid (cmd_valid),
        .io_cmd_ready (cmd_ready),
        .io_cmd_data  (cmd_data),
        .io_cmd_last  (cmd_last),
        .io_rsp_valid (rsp_valid),
        .io_rsp_ready (rsp_ready),
        .io_rsp_data  (rsp_data),
        .io_busy      (busy),
        .io_spi_sclk  (sclk),
        .io_spi_ss    (ss),
        .io_spi_mosi  (mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
        .io_loopback  (loopback),
`endif
        .io_spi_miso  (miso)
    );

    // ---------------- slave model / pin monitor ----------------
    int         cyc = 0;
    logic       sclk_p = 1'b0, ss_p = 1'b1;
    int         bit_idx = 0;
    logic [7:0] mosi_cur = 8'h00, slave_cur = 8'h00, slave_next = 8'h00, slave_dflt = 8'hFF;
    logic [7:0] slave_q[$];
    logic [7:0] mosi_got[$];
    logic [7:0] rsp_got[$];
    int         rise_cnt = 0, frames = 0, period_err = 0, mosi_err = 0;
    int         ss_fall_cyc = 0, ss_rise_cyc = 0, first_rise_cyc = -1;
    int         last_rise_cyc = 0, last_fall_cyc = 0, gap_min = 1000000;
    bit         have_prev_rise = 0;

    always @(negedge io_clock) begin
        cyc++;
        if (io_reset) begin
            sclk_p = 1'b0;
            ss_p = 1'b1;
            bit_idx = 0;
            have_prev_rise = 0;
        end else begin
            if (ss && mosi) mosi_err++;
            if (ss_p && !ss) begin
                if (have_prev_rise && (cyc - ss_rise_cyc) < gap_min) gap_min = cyc - ss_rise_cyc;
                ss_fall_cyc = cyc;
                frames++;
                bit_idx = 0;
                first_rise_cyc = -1;
                slave_next = (slave_q.size() > 0) ? slave_q[0] : slave_dflt;
                miso = slave_next[7];
            end
            if (!ss_p && ss) begin
                ss_rise_cyc = cyc;
                have_prev_rise = 1;
            end
            if (!sclk_p && sclk) begin
                if (bit_idx == 0) begin
                    slave_cur = (slave_q.size() > 0) ? slave_q.pop_front() : slave_dflt;
                end else if (cyc - last_rise_cyc != 2 * CLK_DIV) begin
                    period_err++;
                end
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                last_rise_cyc = cyc;
                rise_cnt++;
                mosi_cur = {mosi_cur[6:0], mosi};
                bit_idx++;
                if (bit_idx == 8) begin
                    mosi_got.push_back(mosi_cur);
                    bit_idx = 0;
                end
            end
            if (sclk_p && !sclk) begin
                if (cyc - last_rise_cyc != CLK_DIV) period_err++;
                last_fall_cyc = cyc;
                if (bit_idx == 0) begin
                    slave_next = (slave_q.size() > 0) ? slave_q[0] : slave_dflt;
                    miso = slave_next[7];
                end else begin
                    miso = slave_cur[7 - bit_idx];
                end
            end
            if (rsp_valid && rsp_ready) rsp_got.push_back(rsp_data);
            sclk_p = sclk;
            ss_p = ss;
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send_cmd(input logic [7:0] d, input logic l);
        int  n = 0;
        bit  got = 0;
        cmd_data = d;
        cmd_last = l;
        cmd_valid = 1'b1;
        while (!got && n < BUDGET) begin
            @(negedge io_clock);
            n++;
            got = cmd_ready;
        end
        @(posedge io_clock);
        #1;
        cmd_valid = 1'b0;
        cmd_data = 8'h00;
        cmd_last = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL cmd_accept_timeout data=%02h ready_seen=%0b required=1", d, got);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge io_clock);
        while (busy && n < BUDGET) begin
            @(negedge io_clock);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b required=0", busy);
        end
        repeat (3) @(negedge io_clock);
        @(posedge io_clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        io_reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge io_clock);
        #1;
        checks++;
        if ({ss, sclk, mosi, cmd_ready, rsp_valid, busy} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_pins got=%06b required=100000", {ss, sclk, mosi, cmd_ready, rsp_valid, busy});
        end
        checks++;
        if (rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rsp_data got=%02h required=00", rsp_data);
        end
        io_reset = 1'b0;
        @(negedge io_clock);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_first_edge got=%0b required=0", cmd_ready);
        end
        @(negedge io_clock);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got=%0b required=1", cmd_ready);
        end
        @(posedge io_clock);
        #1;
    endtask

    task automatic test_single();
        int r0 = rise_cnt;
        mosi_got.delete();
        rsp_got.delete();
        slave_q.delete();
        slave_q.push_back(8'h3C);
        send_cmd(8'hA5, 1'b1);
        wait_idle();
        checks++;
        if (mosi_got.size() != 1 || mosi_got[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_mosi count=%0d first=%02h required=1/a5", mosi_got.size(),
                     (mosi_got.size() > 0) ? mosi_got[0] : 8'h00);
        end
        checks++;
        if (rsp_got.size() != 1 || rsp_got[0] !== 8'h3C) begin
            failures++;
            $display("FAIL single_rsp count=%0d first=%02h required=1/3c", rsp_got.size(),
                     (rsp_got.size() > 0) ? rsp_got[0] : 8'h00);
        end
        checks++;
        if (ss_rise_cyc - ss_fall_cyc != 16 * CLK_DIV + CLK_DIV + CLK_DIV) begin
            failures++;
            $display("FAIL single_ss_low got=%0d required=%0d", ss_rise_cyc - ss_fall_cyc, 18 * CLK_DIV);
        end
        checks++;
        if (first_rise_cyc - ss_fall_cyc != 2 * CLK_DIV) begin
            failures++;
            $display("FAIL single_first_rise got=%0d required=%0d", first_rise_cyc - ss_fall_cyc, 2 * CLK_DIV);
        end
        checks++;
        if (ss_rise_cyc - last_fall_cyc != CLK_DIV) begin
            failures++;
            $display("FAIL single_ss_tail got=%0d required=%0d", ss_rise_cyc - last_fall_cyc, CLK_DIV);
        end
        checks++;
        if (rise_cnt - r0 != 8) begin
            failures++;
            $display("FAIL single_rises got=%0d required=8", rise_cnt - r0);
        end
    endtask

    task automatic test_burst();
        int         r0 = rise_cnt;
        int         f0 = frames;
        logic [7:0] exp_tx[3] = '{8'h01, 8'h02, 8'h03};
        mosi_got.delete();
        rsp_got.delete();
        slave_q.delete();
        slave_dflt = 8'hFF;
        for (int i = 0; i < 3; i++) send_cmd(exp_tx[i], i == 2);
        wait_idle();
        checks++;
        if (frames - f0 != 1) begin
            failures++;
            $display("FAIL burst_ss_frames got=%0d required=1", frames - f0);
        end
        checks++;
        if (rise_cnt - r0 != 24) begin
            failures++;
            $display("FAIL burst_rises got=%0d required=24", rise_cnt - r0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= mosi_got.size() || mosi_got[i] !== exp_tx[i]) begin
                failures++;
                $display("FAIL burst_mosi idx=%0d got=%02h required=%02h", i,
                         (i < mosi_got.size()) ? mosi_got[i] : 8'h00, exp_tx[i]);
            end
            checks++;
            if (i >= rsp_got.size() || rsp_got[i] !== 8'hFF) begin
                failures++;
                $display("FAIL burst_rsp idx=%0d got=%02h required=ff", i,
                         (i < rsp_got.size()) ? rsp_got[i] : 8'h00);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s1 = 8'($urandom), s2 = 8'($urandom);
        logic [7:0] b1 = 8'($urandom), b2 = 8'($urandom);
        int         f0 = frames;
        int         n = 0;
        int         viol = 0;
        bit         got = 0;
        mosi_got.delete();
        rsp_got.delete();
        slave_q.delete();
        slave_q.push_back(s1);
        slave_q.push_back(s2);
        rsp_ready = 1'b0;
        send_cmd(b1, 1'b0);
        cmd_data = b2;
        cmd_last = 1'b1;
        cmd_valid = 1'b1;
        while (!rsp_valid && n < BUDGET) begin
            @(negedge io_clock);
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            failures++;
            $display("FAIL bp_rsp_timeout rsp_valid=%0b required=1", rsp_valid);
        end
        repeat (20) begin
            @(negedge io_clock);
            if (cmd_ready || sclk || !rsp_valid || rsp_data !== s1) viol++;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL bp_stall_violations got=%0d required=0", viol);
        end
        checks++;
        if (rsp_data !== s1) begin
            failures++;
            $display("FAIL bp_held_rsp got=%02h required=%02h", rsp_data, s1);
        end
        @(posedge io_clock);
        #1;
        rsp_ready = 1'b1;
        n = 0;
        while (!got && n < BUDGET) begin
            @(negedge io_clock);
            n++;
            got = cmd_ready;
        end
        @(posedge io_clock);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bp_accept_timeout ready_seen=%0b required=1", got);
        end
        wait_idle();
        checks++;
        if (rsp_got.size() != 2 || rsp_got[0] !== s1 || rsp_got[1] !== s2) begin
            failures++;
            $display("FAIL bp_rsp_order count=%0d required=2 (%02h,%02h)", rsp_got.size(), s1, s2);
        end
        checks++;
        if (mosi_got.size() != 2 || mosi_got[0] !== b1 || mosi_got[1] !== b2) begin
            failures++;
            $display("FAIL bp_mosi count=%0d required=2 (%02h,%02h)", mosi_got.size(), b1, b2);
        end
        checks++;
        if (frames - f0 != 1) begin
            failures++;
            $display("FAIL bp_ss_frames got=%0d required=1", frames - f0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s2 = 8'($urandom);
        int         r0 = rise_cnt;
        int         n = 0;
        mosi_got.delete();
        rsp_got.delete();
        slave_q.delete();
        slave_q.push_back(8'($urandom));
        send_cmd(8'($urandom), 1'b1);
        while (rise_cnt - r0 < 4 && n < BUDGET) begin
            @(negedge io_clock);
            n++;
        end
        checks++;
        if (rise_cnt - r0 < 4) begin
            failures++;
            $display("FAIL mid_rise_timeout got=%0d required=4", rise_cnt - r0);
        end
        @(negedge io_clock);
        #2;
        io_reset = 1'b1;
        #1;
        checks++;
        if ({ss, sclk, rsp_valid, busy, mosi} !== 5'b10000) begin
            failures++;
            $display("FAIL mid_reset_pins got=%05b required=10000", {ss, sclk, rsp_valid, busy, mosi});
        end
        @(posedge io_clock);
        @(posedge io_clock);
        #1;
        io_reset = 1'b0;
        repeat (2 * 16 * CLK_DIV) @(posedge io_clock);
        #1;
        checks++;
        if (rsp_got.size() != 0 || mosi_got.size() != 0) begin
            failures++;
            $display("FAIL mid_abandoned rsp=%0d mosi=%0d required=0/0", rsp_got.size(), mosi_got.size());
        end
        slave_q.delete();
        slave_q.push_back(s2);
        send_cmd(8'h55, 1'b1);
        wait_idle();
        checks++;
        if (mosi_got.size() != 1 || mosi_got[0] !== 8'h55) begin
            failures++;
            $display("FAIL mid_after_mosi count=%0d required=1/55", mosi_got.size());
        end
        checks++;
        if (rsp_got.size() != 1 || rsp_got[0] !== s2) begin
            failures++;
            $display("FAIL mid_after_rsp count=%0d required=1/%02h", rsp_got.size(), s2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[3], s[3];
        int         f0 = frames;
        mosi_got.delete();
        rsp_got.delete();
        slave_q.delete();
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            s[i] = 8'($urandom);
            slave_q.push_back(s[i]);
        end
        gap_min = 1000000;
        for (int i = 0; i < 3; i++) send_cmd(d[i], 1'b1);
        wait_idle();
        checks++;
        if (frames - f0 != 3) begin
            failures++;
            $display("FAIL b2b_frames got=%0d required=3", frames - f0);
        end
        checks++;
        if (gap_min < SS_IDLE) begin
            failures++;
            $display("FAIL b2b_ss_gap got=%0d required>=%0d", gap_min, SS_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rsp_got.size() || rsp_got[i] !== s[i] || i >= mosi_got.size() || mosi_got[i] !== d[i]) begin
                failures++;
                $display("FAIL b2b_data idx=%0d rsp=%02h/%02h mosi=%02h/%02h", i,
                         (i < rsp_got.size()) ? rsp_got[i] : 8'h00, s[i],
                         (i < mosi_got.size()) ? mosi_got[i] : 8'h00, d[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int         len = $urandom_range(1, 3);
            logic [7:0] d[$], s[$];
            mosi_got.delete();
            rsp_got.delete();
            slave_q.delete();
            for (int i = 0; i < len; i++) begin
                d.push_back(8'($urandom));
                s.push_back(8'($urandom));
                slave_q.push_back(s[i]);
            end
            for (int i = 0; i < len; i++) send_cmd(d[i], i == len - 1);
            wait_idle();
            checks++;
            if (rsp_got.size() != len || mosi_got.size() != len) begin
                failures++;
                $display("FAIL rand_count it=%0d rsp=%0d mosi=%0d required=%0d", it,
                         rsp_got.size(), mosi_got.size(), len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    checks++;
                    if (rsp_got[i] !== s[i] || mosi_got[i] !== d[i]) begin
                        failures++;
                        $display("FAIL rand_data it=%0d idx=%0d rsp=%02h/%02h mosi=%02h/%02h",
                                 it, i, rsp_got[i], s[i], mosi_got[i], d[i]);
                    end
                end
            end
        end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback();
        mosi_got.delete();
        rsp_got.delete();
        slave_q.delete();
        slave_dflt = 8'h00;
        loopback = 1'b1;
        send_cmd(8'hC3, 1'b1);
        wait_idle();
        loopback = 1'b0;
        checks++;
        if (rsp_got.size() != 1 || rsp_got[0] !== 8'hC3) begin
            failures++;
            $display("FAIL loopback_rsp count=%0d first=%02h required=1/c3", rsp_got.size(),
                     (rsp_got.size() > 0) ? rsp_got[0] : 8'h00);
        end
        slave_dflt = 8'hFF;
    endtask
`endif

    task automatic test_pin_rules();
        checks++;
        if (mosi_err != 0) begin
            failures++;
            $display("FAIL mosi_while_ss_high got=%0d required=0", mosi_err);
        end
        checks++;
        if (period_err != 0) begin
            failures++;
            $display("FAIL sclk_phase_errors got=%0d required=0", period_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        test_pin_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
